// File: rtl/module_bcd_to_binary_pkg.sv
// pkg_bcd
// Shared definitions for the two-digit BCD to binary converter: the
// controller state encoding, the digit/step/width constants and a small
// digit-range helper.
// Contents:
//   state_t  - controller states IDLE, CONVERT, DONE
//   BCD_MAX  - largest legal BCD digit value
//   N_STEPS  - shift/correct steps needed to drain 7 result bits
//   BIN_W    - width of the binary result
//   SHIFT_W  - width of the {tens, units, bin} shift register
//   is_bcd() - true when a nibble holds a legal decimal digit

package pkg_bcd;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    DONE
  } state_t;

  localparam int BCD_MAX = 9;
  localparam int N_STEPS = 7;
  localparam int BIN_W   = 7;
  localparam int SHIFT_W = 8 + BIN_W;

  function automatic logic is_bcd(input logic [3:0] digit);
    return digit <= 4'(BCD_MAX);
  endfunction

endpackage

// File: rtl/module_bcd_to_binary_correct.sv
// module_bcd_correct
// Nibble correction used by the reverse double-dabble step. After a right
// shift, a BCD digit that reads 8 or more has picked up a bit worth 8 that
// is really worth 5 in decimal terms, so 3 is taken off; smaller values pass
// through unchanged.
// Ports:
//   nibble_in  - shifted BCD nibble
//   nibble_out - corrected BCD nibble

module module_bcd_correct (
  input  logic [3:0] nibble_in,
  output logic [3:0] nibble_out
);

  assign nibble_out = (nibble_in >= 4'd8) ? (nibble_in - 4'd3) : nibble_in;

endmodule

// File: rtl/module_bcd_to_binary.sv
// module_bcd_to_binary
// Converts a two-digit BCD number (tens, units) into a 7-bit binary value
// 0..99 using reverse double-dabble: a 15-bit register {tens, units, bin} is
// shifted right seven times, correcting each BCD nibble after every shift.
// An input digit above 9 skips the conversion and reports err with a zero
// result. Input and output use valid/ready handshakes; one conversion is in
// flight at a time.
// Ports:
//   clk         - system clock, rising edge
//   rst         - synchronous active-high reset
//   bcd_tens    - BCD tens digit
//   bcd_units   - BCD units digit
//   in_valid    - input digits valid
//   in_ready    - block can accept input (IDLE and not in reset)
//   binary_code - registered result 10*tens + units
//   err         - registered flag: an input digit was above 9
//   gray_code   - registered Gray code of the result (GRAY_OUTPUT_EN only)
//   out_valid   - result valid (DONE)
//   out_ready   - downstream accepts the result
// Configuration:
//   GRAY_OUTPUT_EN - when defined, adds the gray_code output and its logic.

module module_bcd_to_binary
  import pkg_bcd::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       bcd_tens,
  input  logic [3:0]       bcd_units,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [BIN_W-1:0] binary_code,
  output logic             err,
`ifdef GRAY_OUTPUT_EN
  output logic [BIN_W-1:0] gray_code,
`endif
  output logic             out_valid,
  input  logic             out_ready
);

  state_t state;
  state_t state_next;

  logic [2:0]         step_cnt;
  logic [SHIFT_W-1:0] shreg;
  logic [SHIFT_W-1:0] shifted;
  logic [SHIFT_W-1:0] stepped;
  logic [3:0]         tens_fix;
  logic [3:0]         units_fix;
  logic               digits_ok;
  logic               last_step;

  // One conversion step: shift the whole register right, then repair each
  // BCD nibble so it stays a legal decimal digit for the next shift.
  assign shifted = shreg >> 1;

  module_bcd_correct u_correct_tens (
    .nibble_in  (shifted[SHIFT_W-1 -: 4]),
    .nibble_out (tens_fix)
  );

  module_bcd_correct u_correct_units (
    .nibble_in  (shifted[SHIFT_W-5 -: 4]),
    .nibble_out (units_fix)
  );

  assign stepped   = {tens_fix, units_fix, shifted[BIN_W-1:0]};
  assign digits_ok = is_bcd(bcd_tens) & is_bcd(bcd_units);
  assign last_step = (step_cnt == 3'(N_STEPS - 1));

  // Next-state and handshake decode. in_ready and out_valid come straight
  // from the state so the handshakes need no extra register stage. In IDLE
  // in_valid alone is enough to move on because in_ready is high there
  // whenever reset is low, and reset overrides the transition anyway.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid) begin
          state_next = digits_ok ? CONVERT : DONE;
        end
      end
      CONVERT: begin
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register and datapath. Digits are captured on the accept edge;
  // the seventh CONVERT edge writes the drained binary bits straight into
  // the result register so it is ready the moment DONE is entered. Results
  // and err are only written on accept and on the last step, so they hold
  // steady for as long as DONE waits on out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      step_cnt    <= 3'd0;
      shreg       <= '0;
      binary_code <= '0;
      err         <= 1'b0;
`ifdef GRAY_OUTPUT_EN
      gray_code   <= '0;
`endif
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg    <= {bcd_tens, bcd_units, {BIN_W{1'b0}}};
            step_cnt <= 3'd0;
            if (digits_ok) begin
              err <= 1'b0;
            end else begin
              err         <= 1'b1;
              binary_code <= '0;
`ifdef GRAY_OUTPUT_EN
              gray_code   <= '0;
`endif
            end
          end
        end
        CONVERT: begin
          shreg    <= stepped;
          step_cnt <= step_cnt + 3'd1;
          if (last_step) begin
            binary_code <= stepped[BIN_W-1:0];
`ifdef GRAY_OUTPUT_EN
            gray_code   <= stepped[BIN_W-1:0] ^ (stepped[BIN_W-1:0] >> 1);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_module_bcd_to_binary.sv
// tb_module_bcd_to_binary
// Self-checking bench for module_bcd_to_binary. A behavioural model (plain
// decimal arithmetic) predicts each transaction's result; a compare process
// checks every cycle that out_valid is high against that prediction, and a
// few literal expectations pin the model on known values. Stimulus covers
// reset state, hand-picked values, back-pressure, a mid-conversion reset and
// a sweep of all valid pairs plus random invalid pairs with random
// out_ready delays. Digits and in_valid are randomised while the block is
// busy and must be ignored.

module tb_module_bcd_to_binary;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_units;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] binary_code;
  logic       err;
  logic       out_valid;
  logic       out_ready;
`ifdef GRAY_OUTPUT_EN
  logic [6:0] gray_code;
`endif

  int passCount  = 0;
  int checkCount = 0;

  int   expBin    = 0;
  int   expGray   = 0;
  logic expErr    = 1'b0;
  logic expActive = 1'b0;

  module_bcd_to_binary dut (
    .clk         (clk),
    .rst         (rst),
    .bcd_tens    (bcd_tens),
    .bcd_units   (bcd_units),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .binary_code (binary_code),
    .err         (err),
`ifdef GRAY_OUTPUT_EN
    .gray_code   (gray_code),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  // Decimal model: the value two digits stand for, or zero when either
  // digit is not a decimal digit.
  function automatic int modelBin(input int t, input int u);
    if (t > 9 || u > 9) return 0;
    return 10 * t + u;
  endfunction

  function automatic int modelGray(input int b);
    return b ^ (b / 2);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: actual %0d required %0d", name, actual, expected);
  endtask

  // Every cycle a result is presented it must match the model and the
  // block must not be offering to accept input; a result with nothing
  // outstanding (e.g. after an aborting reset) is an error.
  always @(negedge clk) begin
    if (out_valid) begin
      if (expActive) begin
        checkOutput("binary_code", int'(binary_code), expBin);
        checkOutput("err", int'(err), int'(expErr));
        checkOutput("in_ready_while_done", int'(in_ready), 0);
`ifdef GRAY_OUTPUT_EN
        checkOutput("gray_code", int'(gray_code), expGray);
`endif
      end else begin
        checkOutput("spurious_out_valid", int'(out_valid), 0);
      end
    end
  end

  // One full transaction: offer digits, wait (bounded) for the result,
  // hold off the handshake for 'hold' cycles, then complete it.
  task automatic applyStimulus(input int t, input int u, input int hold,
                               input int litBin, input int litGray);
    int n;
    @(negedge clk);
    bcd_tens  = 4'(t);
    bcd_units = 4'(u);
    in_valid  = 1'b1;
    checkOutput("in_ready_idle", int'(in_ready), 1);
    @(posedge clk);
    expBin    = modelBin(t, u);
    expGray   = modelGray(expBin);
    expErr    = (t > 9 || u > 9);
    expActive = 1'b1;
    #1 in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      in_valid  = 1'($urandom);
      bcd_tens  = 4'($urandom);
      bcd_units = 4'($urandom);
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    checkOutput("latency", n, expErr ? 0 : 7);
    if (litBin >= 0) checkOutput("literal_bin", int'(binary_code), litBin);
`ifdef GRAY_OUTPUT_EN
    if (litGray >= 0) checkOutput("literal_gray", int'(gray_code), litGray);
`else
    if (litGray < -1) $display("[TB] unexpected gray literal %0d", litGray);
`endif
    for (int i = 0; i < hold; i++) begin
      in_valid  = 1'($urandom);
      bcd_tens  = 4'($urandom);
      bcd_units = 4'($urandom);
      out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    expActive = 1'b0;
    @(negedge clk);
    checkOutput("in_ready_after_handshake", int'(in_ready), 1);
    checkOutput("out_valid_after_handshake", int'(out_valid), 0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t;
    int u;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    bcd_tens  = 4'd0;
    bcd_units = 4'd0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_in_ready", int'(in_ready), 0);
    checkOutput("reset_binary_code", int'(binary_code), 0);
    checkOutput("reset_err", int'(err), 0);
    rst = 1'b0;
    #1 checkOutput("in_ready_first_edge", int'(in_ready), 1);

    // Hand-picked values with literal expectations.
    applyStimulus(4, 2, 0, 42, 63);
    applyStimulus(9, 9, 1, 99, 82);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(10, 3, 0, 0, 0);
    applyStimulus(5, 7, 5, 57, 37);

    // Reset three steps into a conversion aborts it silently.
    @(negedge clk);
    bcd_tens  = 4'd5;
    bcd_units = 4'd7;
    in_valid  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_binary_code", int'(binary_code), 0);
    checkOutput("abort_err", int'(err), 0);
    checkOutput("abort_out_valid", int'(out_valid), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 checkOutput("abort_in_ready_release", int'(in_ready), 1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    checkOutput("abort_no_result", int'(out_valid), 0);
    applyStimulus(7, 5, 0, 75, -1);

    // Every valid pair with random back-pressure.
    for (int ti = 0; ti < 10; ti++) begin
      for (int ui = 0; ui < 10; ui++) begin
        applyStimulus(ti, ui, int'($urandom_range(0, 3)), -1, -1);
      end
    end

    // Random invalid pairs.
    for (int k = 0; k < 56; k++) begin
      do begin
        t = int'($urandom_range(0, 15));
        u = int'($urandom_range(0, 15));
      end while (t <= 9 && u <= 9);
      applyStimulus(t, u, int'($urandom_range(0, 3)), 0, -1);
    end

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
